// File: rtl/types_pkg.sv
// Shared types for the fetch path: 32-bit word and the fetch entry
// bundle {address, data} carried from fetch_unit to decode/branch_unit.
package types_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t address;
      word_t data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t, power-of-two depth, flush has priority.
// Ports: clk, reset (async active-low), push/din, pop, flush, full, empty, count, head.
module fetch_fifo
   import types_pkg::*;
#(
   parameter int depth = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             din,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count,
   output fetch_entry_t             head
);

   localparam int aw = $clog2(depth);

   fetch_entry_t          mem [depth];
   logic [aw-1:0]         wr_ptr;
   logic [aw-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full  = (count == (aw+1)'(depth));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // a pop frees the slot the same cycle, so push is allowed when full
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential fetch, bus handshake, prefetch FIFO, redirect.
// Ports: clk, reset (async active-low), redirect/redirect_pc, mem_* bus, out_* stream.
// Option FETCH_STALL_COUNTER_EN adds stall_count (cycles consumer ready but starved).
module fetch_unit
   import types_pkg::*;
#(
   parameter word_t boot_address = 32'h0,
   parameter int    fifo_depth   = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   redirect,
   input  word_t  redirect_pc,
   output logic   mem_valid,
   output word_t  mem_address,
   input  logic   mem_ready,
   input  word_t  mem_rdata,
   output logic   out_valid,
   input  logic   out_ready,
   output word_t  out_address,
   output word_t  out_data,
   output word_t  out_pc_next
`ifdef FETCH_STALL_COUNTER_EN
   ,
   output word_t  stall_count
`endif
);

   typedef enum logic {FETCH, DISCARD} fetch_state_t;

   fetch_state_t                   state;
   fetch_state_t                   state_nxt;
   word_t                          fetch_ptr;
   word_t                          stale_addr;
   logic                           run;
   logic                           push;
   logic                           full;
   logic                           empty;
   logic [$clog2(fifo_depth):0]    count;
   fetch_entry_t                   head;
   fetch_entry_t                   din;

   always_comb begin
      state_nxt   = state;
      mem_valid   = 1'b0;
      mem_address = fetch_ptr;
      unique case (state)
         FETCH: begin
            mem_valid = run && !full;
            if (redirect && mem_valid && !mem_ready)
               state_nxt = DISCARD;
         end
         DISCARD: begin
            // hold the stale request stable until the bus takes it
            mem_valid   = 1'b1;
            mem_address = stale_addr;
            if (mem_ready)
               state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   assign push = (state == FETCH) && mem_valid && mem_ready && !redirect;
   assign din  = '{address: fetch_ptr, data: mem_rdata};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FETCH;
         fetch_ptr  <= boot_address;
         stale_addr <= '0;
         run        <= 1'b0;
      end else begin
         run   <= 1'b1;
         state <= state_nxt;
         if (redirect)
            fetch_ptr <= {redirect_pc[31:2], 2'b00};
         else if (push)
            fetch_ptr <= fetch_ptr + 32'd4;
         if (state == FETCH && state_nxt == DISCARD)
            stale_addr <= fetch_ptr;
      end
   end

   fetch_fifo #(
      .depth (fifo_depth)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (out_ready),
      .flush (redirect),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   assign out_valid   = (count != '0);
   assign out_address = empty ? '0 : head.address;
   assign out_data    = empty ? '0 : head.data;
   assign out_pc_next = empty ? '0 : head.address + 32'd4;

`ifdef FETCH_STALL_COUNTER_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count <= '0;
      else if (out_ready && !out_valid)
         stall_count <= stall_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// bus/consumer/redirect traffic against a queue-based reference model.
module tb_fetch_unit;
   import types_pkg::*;

   logic  clk = 1'b0;
   logic  reset = 1'b0;
   logic  redirect = 1'b0;
   word_t redirect_pc = '0;
   logic  mem_ready = 1'b0;
   logic  out_ready = 1'b0;
   logic  mem_valid;
   logic  out_valid;
   word_t mem_address;
   word_t mem_rdata;
   word_t out_address;
   word_t out_data;
   word_t out_pc_next;
`ifdef FETCH_STALL_COUNTER_EN
   word_t stall_count;
`endif

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_valid   (mem_valid),
      .mem_address (mem_address),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_address (out_address),
      .out_data    (out_data),
      .out_pc_next (out_pc_next)
`ifdef FETCH_STALL_COUNTER_EN
      ,
      .stall_count (stall_count)
`endif
   );

   function automatic word_t mem_word(word_t a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
   endfunction

   assign mem_rdata = mem_word(mem_address);

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, word_t got, word_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model: buffered addresses in order, next fetch address,
   // and whether a stale bus request still has to be absorbed
   word_t q[$];
   bit    running;
   bit    disc;
   word_t ptr;
   word_t disc_addr;
   word_t m_stall;

   task automatic model_reset();
      q.delete();
      running = 0;
      disc    = 0;
      ptr     = 32'h0;
      m_stall = 0;
   endtask

   task automatic step(bit rd, word_t rpc, bit mr, bit ordy);
      bit    e_mv;
      bit    e_ov;
      word_t e_ma;
      word_t e_oa;
      @(negedge clk);
      e_mv = running && (disc || q.size() < 2);
      e_ma = disc ? disc_addr : ptr;
      e_ov = q.size() > 0;
      e_oa = e_ov ? q[0] : 32'h0;
      chk("mem_valid", mem_valid, e_mv);
      if (e_mv) chk("mem_address", mem_address, e_ma);
      chk("out_valid", out_valid, e_ov);
      chk("out_address", out_address, e_oa);
      chk("out_data", out_data, e_ov ? mem_word(e_oa) : 32'h0);
      chk("out_pc_next", out_pc_next, e_ov ? e_oa + 32'd4 : 32'h0);
`ifdef FETCH_STALL_COUNTER_EN
      chk("stall_count", stall_count, m_stall);
`endif
      redirect    = rd;
      redirect_pc = rpc;
      mem_ready   = mr;
      out_ready   = ordy;
      if (ordy && !e_ov) m_stall++;
      if (rd) begin
         if (!disc && e_mv && !mr) begin
            disc      = 1;
            disc_addr = ptr;
         end else if (disc && mr) begin
            disc = 0;
         end
         q.delete();
         ptr = {rpc[31:2], 2'b00};
      end else begin
         if (e_ov && ordy) void'(q.pop_front());
         if (disc) begin
            if (mr) disc = 0;
         end else if (e_mv && mr) begin
            q.push_back(ptr);
            ptr = ptr + 32'd4;
         end
      end
      running = 1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset    = 1'b0;
      redirect = 1'b0;
      #1;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_out_valid", out_valid, 0);
`ifdef FETCH_STALL_COUNTER_EN
      chk("rst_stall", stall_count, 0);
`endif
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      model_reset();

      // 1: streaming at full throughput
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
      chk("t1_pc_next", out_pc_next, out_address + 32'd4);

      // 2: consumer stalled, FIFO fills with 0 and 4, then drains
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
      chk("t2_idle", mem_valid, 0);
      chk("t2_head", out_address, 32'h0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

      // 3: redirect with FIFO full
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      step(1, 32'h100, 1, 1);
      step(0, 0, 1, 0);
      chk("t3_flush", out_valid, 0);
      chk("t3_addr", mem_address, 32'h100);
      step(0, 0, 1, 1);
      chk("t3_first", out_address, 32'h100);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

      // 4: redirect while request to 8 is pending
      do_reset();
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      chk("t4_pend", mem_address, 32'h8);
      step(1, 32'h200, 0, 1);
      step(0, 0, 0, 1);
      chk("t4_hold", mem_address, 32'h8);
      step(0, 0, 1, 1);
      chk("t4_hold2", mem_address, 32'h8);
      step(0, 0, 1, 1);
      chk("t4_new", mem_address, 32'h200);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

      // 5: unaligned redirect and address wrap
      step(1, 32'h203, 1, 1);
      step(0, 0, 1, 1);
      chk("t5_align", mem_address, 32'h200);
      step(1, 32'hFFFF_FFFC, 1, 1);
      step(0, 0, 1, 1);
      chk("t5_top", mem_address, 32'hFFFF_FFFC);
      step(0, 0, 1, 1);
      chk("t5_wrap", mem_address, 32'h0);
      chk("t5_pcn", out_pc_next, 32'h0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

      // 6: reset mid-transfer with one entry buffered
      do_reset();
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("t6_pend", mem_valid, 1);
      chk("t6_one", out_valid, 1);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1);

      // random traffic
      do_reset();
      step(0, 0, 1, 1);
      for (int i = 0; i < 1500; i++) begin
         bit    rd;
         word_t rpc;
         rd  = ($urandom_range(0, 15) == 0);
         rpc = $urandom;
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         step(rd, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      end
      step(0, 0, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
